// File: rtl/spi_transaction_arbiter.sv
// spi_transaction_arbiter
//   Shares one half-duplex SPI transaction engine between NUM_REQ requesters.
//   Requests are granted round-robin, one transaction in flight at a time.
//   Each accepted request is launched to the engine as a one-cycle nonzero
//   length. The arbiter then waits for the engine's done pulse, or gives up
//   after TIMEOUT_CYCLES. Read data and a status code are returned to the
//   requester that owns the transaction.
//
// Ports
//   fabric_clk, reset_n          clock, asynchronous active-low reset
//   req_valid / req_ready        per-requester handshake (ready is one-hot or zero)
//   req_length/data/rw_mask      packed per-requester fields, requester i at slice i
//   resp_valid                   one-cycle response pulse to the owning requester
//   resp_read_data, resp_error   shared response bus, qualified by resp_valid
//                                error: 00 ok, 01 bad length, 10 timeout
//   spi_transaction_*            engine launch (length nonzero for one cycle)
//   spi_done, spi_read_data      engine completion pulse and its read data
//   busy                         high whenever the arbiter is not idle
module spi_transaction_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                                    fabric_clk,
  input  logic                                    reset_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]           req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]           req_rw_mask,
  output logic [NUM_REQ-1:0]                      resp_valid,
  output logic [DATA_WIDTH-1:0]                   resp_read_data,
  output logic [1:0]                              resp_error,
  output logic [TRANSACTION_LEN_WIDTH-1:0]        spi_transaction_length,
  output logic [DATA_WIDTH-1:0]                   spi_transaction_data,
  output logic [DATA_WIDTH-1:0]                   spi_transaction_rw_mask,
  input  logic                                    spi_done,
  input  logic [DATA_WIDTH-1:0]                   spi_read_data,
  output logic                                    busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                           state, state_nxt;
  logic [PTR_W-1:0]                 ptr_q, owner_q, grant_idx;
  logic                             grant_any;
  logic                             len_bad;
  logic                             timeout_hit;
  logic [CNT_W-1:0]                 cnt_q;
  logic [1:0]                       err_q;
  logic [TRANSACTION_LEN_WIDTH-1:0] len_q, sel_len;
  logic [DATA_WIDTH-1:0]            data_q, mask_q, rdata_q;
  logic [DATA_WIDTH-1:0]            sel_data, sel_mask;

  // Read bits are only meaningful where the mask marks a read (0) and the
  // bit lies inside the transferred length; everything else is zeroed.
  function automatic logic [DATA_WIDTH-1:0] mask_read(
    input logic [DATA_WIDTH-1:0]            rd,
    input logic [DATA_WIDTH-1:0]            mask,
    input logic [TRANSACTION_LEN_WIDTH-1:0] len
  );
    logic [DATA_WIDTH-1:0] res;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      res[b] = rd[b] & ~mask[b] & (b < int'(len));
    end
    return res;
  endfunction

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign sel_len  = req_length[int'(grant_idx)*TRANSACTION_LEN_WIDTH +: TRANSACTION_LEN_WIDTH];
  assign sel_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_mask = req_rw_mask[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign len_bad  = (sel_len == '0) || (int'(sel_len) > DATA_WIDTH);

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = len_bad ? RESP : ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      // A done pulse on the last timeout cycle still counts as success.
      WAIT:    if (spi_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 2'b00;
      len_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_q <= grant_idx;
            ptr_q   <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            len_q   <= sel_len;
            data_q  <= sel_data;
            mask_q  <= sel_mask;
            err_q   <= len_bad ? 2'b01 : 2'b00;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (spi_done)         err_q <= 2'b00;
          else if (timeout_hit) err_q <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Response data is only visible in RESP, so it needs no reset.
  always_ff @(posedge fabric_clk) begin
    if (state == IDLE && grant_any) begin
      rdata_q <= '0;
    end else if (state == WAIT) begin
      if (spi_done)         rdata_q <= mask_read(spi_read_data, mask_q, len_q);
      else if (timeout_hit) rdata_q <= '0;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[owner_q] = 1'b1;
  end

  assign resp_read_data          = (state == RESP)  ? rdata_q : '0;
  assign resp_error              = (state == RESP)  ? err_q   : 2'b00;
  assign spi_transaction_length  = (state == ISSUE) ? len_q   : '0;
  assign spi_transaction_data    = data_q;
  assign spi_transaction_rw_mask = mask_q;
  assign busy                    = (state != IDLE);

endmodule
